// File: rtl/soc_system_sysid_checker.sv
// Reads the sysid slave (word 0 = ID, word 1 = build timestamp) after reset and on rescan,
// compares both words with the expected build and latches values plus pass/fail/timeout status.
module soc_system_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
   parameter logic [31:0] EXPECTED_TS    = 32'h537A4F74,
   parameter int          TIMEOUT_CYCLES = 256,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic        avm_readdatavalid,
   input  logic [31:0] avm_readdata,
   input  logic        rescan,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   typedef enum logic [2:0] {IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, FIN} state_t;

   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_reg;
   logic [15:0] tcount_reg;
   logic        auto_pending_reg;
   logic        accept;
   logic        expired;
   logic [15:0] tcount_inc;

   assign accept     = avm_read && !avm_waitrequest;
   assign expired    = (tcount_reg >= TIMEOUT_LAST);
   assign tcount_inc = (tcount_reg == 16'hFFFF) ? tcount_reg : tcount_reg + 16'd1;
   assign busy       = (state_reg != IDLE);

   // The awaited event always wins over the timeout when both land in the same cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg        <= IDLE;
         tcount_reg       <= '0;
         auto_pending_reg <= AUTO_START;
         avm_read         <= 1'b0;
         avm_address      <= 1'b0;
         done             <= 1'b0;
         id_ok            <= 1'b0;
         ts_ok            <= 1'b0;
         timeout          <= 1'b0;
         id_value         <= '0;
         ts_value         <= '0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (rescan || auto_pending_reg) begin
                  auto_pending_reg <= 1'b0;
                  state_reg        <= REQ_ID;
                  avm_read         <= 1'b1;
                  avm_address      <= 1'b0;
                  tcount_reg       <= '0;
                  id_ok            <= 1'b0;
                  ts_ok            <= 1'b0;
                  timeout          <= 1'b0;
               end
            end
            REQ_ID: begin
               if (accept && avm_readdatavalid) begin
                  // Zero-latency slave: capture now and chain straight into the TS request.
                  id_value    <= avm_readdata;
                  id_ok       <= (avm_readdata == EXPECTED_ID);
                  state_reg   <= REQ_TS;
                  avm_address <= 1'b1;
                  tcount_reg  <= '0;
               end else if (accept) begin
                  avm_read   <= 1'b0;
                  state_reg  <= WAIT_ID;
                  tcount_reg <= tcount_inc;
               end else if (expired) begin
                  avm_read  <= 1'b0;
                  timeout   <= 1'b1;
                  done      <= 1'b1;
                  state_reg <= FIN;
               end else begin
                  tcount_reg <= tcount_inc;
               end
            end
            WAIT_ID: begin
               if (avm_readdatavalid) begin
                  id_value    <= avm_readdata;
                  id_ok       <= (avm_readdata == EXPECTED_ID);
                  state_reg   <= REQ_TS;
                  avm_read    <= 1'b1;
                  avm_address <= 1'b1;
                  tcount_reg  <= '0;
               end else if (expired) begin
                  timeout   <= 1'b1;
                  done      <= 1'b1;
                  state_reg <= FIN;
               end else begin
                  tcount_reg <= tcount_inc;
               end
            end
            REQ_TS: begin
               if (accept && avm_readdatavalid) begin
                  ts_value  <= avm_readdata;
                  ts_ok     <= (avm_readdata == EXPECTED_TS);
                  avm_read  <= 1'b0;
                  done      <= 1'b1;
                  state_reg <= FIN;
               end else if (accept) begin
                  avm_read   <= 1'b0;
                  state_reg  <= WAIT_TS;
                  tcount_reg <= tcount_inc;
               end else if (expired) begin
                  avm_read  <= 1'b0;
                  timeout   <= 1'b1;
                  done      <= 1'b1;
                  state_reg <= FIN;
               end else begin
                  tcount_reg <= tcount_inc;
               end
            end
            WAIT_TS: begin
               if (avm_readdatavalid) begin
                  ts_value  <= avm_readdata;
                  ts_ok     <= (avm_readdata == EXPECTED_TS);
                  done      <= 1'b1;
                  state_reg <= FIN;
               end else if (expired) begin
                  timeout   <= 1'b1;
                  done      <= 1'b1;
                  state_reg <= FIN;
               end else begin
                  tcount_reg <= tcount_inc;
               end
            end
            FIN: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Self-checking bench: behavioural sysid slave, table of scan vectors, scoreboard of expected scan results.
module tb_soc_system_sysid_checker;

   localparam int          TO     = 16;
   localparam logic [31:0] EXP_ID = 32'hACD51302;
   localparam logic [31:0] EXP_TS = 32'h537A4F74;

   logic        clock, reset_n;
   logic        avm_address, avm_read, avm_waitrequest, avm_readdatavalid;
   logic [31:0] avm_readdata;
   logic        rescan, busy, done, id_ok, ts_ok, timeout;
   logic [31:0] id_value, ts_value;

   soc_system_sysid_checker #(
      .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(TO), .AUTO_START(1'b1)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
      .avm_readdatavalid(avm_readdatavalid), .avm_readdata(avm_readdata),
      .rescan(rescan), .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok),
      .timeout(timeout), .id_value(id_value), .ts_value(ts_value)
   );

   typedef struct {
      logic [31:0] id_data;
      logic [31:0] ts_data;
      int          wait_n;
      int          lat;
      bit          drop_ts;
      logic        exp_id_ok;
      logic        exp_ts_ok;
      logic        exp_tmo;
   } vec_t;

   typedef struct {
      int          done_cyc;
      logic        id_ok;
      logic        ts_ok;
      logic        tmo;
      logic [31:0] id_v;
      logic [31:0] ts_v;
   } exp_t;

   int          n_cmp = 0, n_bad = 0, cyc = 0, done_count = 0, push_count = 0;
   exp_t        sb_q[$];
   exp_t        last_exp, mon_e;
   logic [31:0] cfg_id, cfg_ts, last_ts;
   int          cfg_wait, cfg_lat;
   bit          cfg_drop_ts, stray_req;
   int          pend, stall;
   logic [31:0] pend_data;
   logic        stall_addr;
   vec_t        vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Slave model: answers 1ns after each edge, so the DUT samples the response on the next edge.
   initial begin
      avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 32'hDEADBEEF;
      pend = 0; stall = 0; stall_addr = 1'b0; pend_data = '0;
      forever begin
         @(posedge clock); #1;
         avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 32'hDEADBEEF;
         if (!reset_n) begin
            pend = 0; stall = 0;
         end else begin
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin avm_readdatavalid = 1'b1; avm_readdata = pend_data; end
            end
            if (stray_req) begin avm_readdatavalid = 1'b1; avm_readdata = 32'h5A5A5A5A; end
            if (stall > 0) begin
               chk_bit("read_held", avm_read, 1'b1);
               chk_bit("addr_stable", avm_address, stall_addr);
            end
            if (avm_read) begin
               if (stall == 0) stall_addr = avm_address;
               if (stall < cfg_wait) begin
                  avm_waitrequest = 1'b1;
                  stall++;
               end else begin
                  stall = 0;
                  if (!(cfg_drop_ts && avm_address)) begin
                     if (cfg_lat == 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata = avm_address ? cfg_ts : cfg_id;
                     end else begin
                        pend = cfg_lat;
                        pend_data = avm_address ? cfg_ts : cfg_id;
                     end
                  end
               end
            end else begin
               stall = 0;
            end
         end
      end
   end

   // Scoreboard consumer: one line per finished scan.
   initial forever begin
      @(negedge clock);
      if (reset_n && done) begin
         done_count++;
         if (sb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_done: got done=1 expected no scan pending (cycle %0d)", cyc);
         end else begin
            mon_e = sb_q.pop_front();
            $display("scan done cyc=%0d id=%h ts=%h id_ok=%b ts_ok=%b timeout=%b",
                     cyc, id_value, ts_value, id_ok, ts_ok, timeout);
            chk("done_cycle", cyc, mon_e.done_cyc);
            chk_bit("id_ok", id_ok, mon_e.id_ok);
            chk_bit("ts_ok", ts_ok, mon_e.ts_ok);
            chk_bit("timeout", timeout, mon_e.tmo);
            chk("id_value", id_value, mon_e.id_v);
            chk("ts_value", ts_value, mon_e.ts_v);
            chk_bit("read_at_done", avm_read, 1'b0);
         end
      end
   end

   // Done cycle: REQ_ID one cycle after the start, each completed read spans (wait+1+lat) cycles,
   // an unanswered TS read spans TO cycles.
   task automatic push_exp(input int c0, input int w, input int l, input bit drop,
                           input logic iok, input logic tok, input logic tmo,
                           input logic [31:0] idv, input logic [31:0] tsv);
      exp_t e;
      e.done_cyc = c0 + 1 + (w + 1 + l) + (drop ? TO : (w + 1 + l));
      e.id_ok = iok; e.ts_ok = tok; e.tmo = tmo; e.id_v = idv; e.ts_v = tsv;
      sb_q.push_back(e);
      last_exp = e;
      push_count++;
   endtask

   task automatic do_rescan(input vec_t v);
      cfg_id = v.id_data; cfg_ts = v.ts_data; cfg_wait = v.wait_n; cfg_lat = v.lat;
      cfg_drop_ts = v.drop_ts;
      @(posedge clock); #1;
      rescan = 1'b1;
      push_exp(cyc, v.wait_n, v.lat, v.drop_ts, v.exp_id_ok, v.exp_ts_ok, v.exp_tmo,
               v.id_data, v.drop_ts ? last_ts : v.ts_data);
      if (!v.drop_ts) last_ts = v.ts_data;
      @(posedge clock); #1;
      rescan = 1'b0;
      chk_bit("busy_in_scan", busy, 1'b1);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (k < 300 && sb_q.size() != 0) begin
         @(posedge clock);
         k++;
      end
      if (sb_q.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL scan_timeout: got %0d results pending expected 0 after %0d cycles", sb_q.size(), k);
         sb_q.delete();
      end
      repeat (2) @(posedge clock);
      #1;
      chk_bit("busy_after", busy, 1'b0);
   endtask

   task automatic stray_check();
      @(negedge clock); stray_req = 1'b1;
      @(negedge clock); stray_req = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("stray_id_value", id_value, last_exp.id_v);
      chk("stray_ts_value", ts_value, last_exp.ts_v);
      chk_bit("stray_timeout", timeout, last_exp.tmo);
      chk_bit("stray_busy", busy, 1'b0);
   endtask

   initial begin
      vecs[0] = '{EXP_ID,       EXP_TS,       0, 1, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{32'h00000000, EXP_TS,       0, 1, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{EXP_ID,       EXP_TS,       3, 1, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{EXP_ID,       EXP_TS,       0, 0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{EXP_ID,       32'h00001234, 1, 2, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{EXP_ID,       EXP_TS,       0, 1, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{32'hFFFFFFFF, 32'h537A4F75, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{EXP_ID,       EXP_TS,       0, 1, 1'b0, 1'b1, 1'b1, 1'b0};

      reset_n = 1'b0; rescan = 1'b0; stray_req = 1'b0; last_ts = '0;
      cfg_id = EXP_ID; cfg_ts = EXP_TS; cfg_wait = 0; cfg_lat = 1; cfg_drop_ts = 1'b0;
      repeat (2) @(negedge clock);
      chk_bit("rst_busy", busy, 1'b0);       chk_bit("rst_done", done, 1'b0);
      chk_bit("rst_id_ok", id_ok, 1'b0);     chk_bit("rst_ts_ok", ts_ok, 1'b0);
      chk_bit("rst_timeout", timeout, 1'b0); chk_bit("rst_read", avm_read, 1'b0);
      chk_bit("rst_address", avm_address, 1'b0);
      chk("rst_id_value", id_value, 32'h0);  chk("rst_ts_value", ts_value, 32'h0);

      // Auto-start scan on reset release.
      @(posedge clock); #1;
      reset_n = 1'b1;
      push_exp(cyc, 0, 1, 1'b0, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);
      last_ts = EXP_TS;
      wait_idle();

      for (int i = 0; i < 8; i++) begin
         do_rescan(vecs[i]);
         wait_idle();
         stray_check();
      end

      // rescan pulsed while busy and again in the FIN cycle: both ignored.
      do_rescan(vecs[0]);
      @(posedge clock); #1; rescan = 1'b1;
      @(posedge clock); #1; rescan = 1'b0;
      @(posedge clock); #1;
      @(posedge clock); #1; rescan = 1'b1;
      @(posedge clock); #1; rescan = 1'b0;
      wait_idle();
      repeat (12) @(posedge clock);
      chk("done_pulses_busy_rescan", done_count, push_count);

      // Asynchronous reset while waiting for the ID data, then an auto-started scan.
      vecs[0].lat = 3;
      do_rescan(vecs[0]);
      @(posedge clock); #3;
      reset_n = 1'b0;
      sb_q.delete();
      push_count--;
      #1;
      chk_bit("mid_rst_busy", busy, 1'b0);       chk_bit("mid_rst_done", done, 1'b0);
      chk_bit("mid_rst_id_ok", id_ok, 1'b0);     chk_bit("mid_rst_ts_ok", ts_ok, 1'b0);
      chk_bit("mid_rst_timeout", timeout, 1'b0); chk_bit("mid_rst_read", avm_read, 1'b0);
      chk_bit("mid_rst_address", avm_address, 1'b0);
      chk("mid_rst_id_value", id_value, 32'h0);  chk("mid_rst_ts_value", ts_value, 32'h0);
      cfg_lat = 1;
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b1;
      push_exp(cyc, 0, 1, 1'b0, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);
      wait_idle();
      repeat (5) @(posedge clock);
      chk("done_pulses_total", done_count, push_count);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
